// File: rtl/mem_operand_fetch.sv
// mem_operand_fetch: streams operand pairs from the opa/opb RAM banks.
// Optional build macro: MC_STALL_CNT_EN (adds stall_cnt output).
//
// A start command loads the base addresses and a pair count. The block then
// issues one address pair per cycle, tracks the two-cycle RAM read latency,
// and queues the returned pairs in a small FIFO read by a valid/ready stream.
//
// Ports:
//   mem_clk, mem_rst              clock, synchronous active-high reset
//   start, base_addr_opa/opb      command pulse and first addresses
//   count                         number of pairs in the command
//   busy, done                    command in progress / completion pulse
//   mc_address_mem_opa/opb        registered read addresses to the RAM
//   mem_data_out_opa/opb          RAM read data
//   op_valid, op_ready            output stream handshake
//   op_a, op_b, op_last           FIFO head pair and final-pair flag
//   stall_cnt                     valid-but-not-ready cycles (optional)

module mem_operand_fetch #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 128,
  parameter int CNT_W      = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr_opa,
  input  logic [ADDR_W-1:0] base_addr_opb,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mc_address_mem_opa,
  output logic [ADDR_W-1:0] mc_address_mem_opb,
  input  logic [DATA_W-1:0] mem_data_out_opa,
  input  logic [DATA_W-1:0] mem_data_out_opb,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_last
`ifdef MC_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_V =
    (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] nxt_a_q, nxt_b_q;
  logic [CNT_W-1:0]  rem_q;
  logic [1:0]        pv_q, pl_q;

  logic [DATA_W-1:0] fa_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fb_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fl_q;
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;

  logic          accept, pop, push;
  logic          issue, pop_last;
  logic          rem_one;
  logic [PW+1:0] occ;

  assign accept   = start && (state_q == IDLE);
  assign pop      = op_valid && op_ready;
  assign push     = pv_q[1];
  assign pop_last = pop && op_last;
  assign rem_one  = (rem_q == CNT_W'(1));

  // Slots already claimed: queued plus in flight,
  // minus the one leaving this cycle.
  assign occ = {1'b0, cnt_q}
             + (PW+2)'(pv_q[0])
             + (PW+2)'(pv_q[1])
             - (PW+2)'(pop);

  assign issue = (state_q == READ)
              && (rem_q != '0)
              && (occ < DEPTH_V);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start && count != '0)
          state_d = READ;
      READ:
        if (issue && rem_one)
          state_d = DRAIN;
      DRAIN:
        if (pop_last)
          state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (mem_rst) begin
      state_q            <= IDLE;
      nxt_a_q            <= '0;
      nxt_b_q            <= '0;
      rem_q              <= '0;
      mc_address_mem_opa <= '0;
      mc_address_mem_opb <= '0;
      pv_q               <= '0;
      pl_q               <= '0;
      wp_q               <= '0;
      rp_q               <= '0;
      cnt_q              <= '0;
      done               <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (accept && count == '0)
              || pop_last;
      if (accept) begin
        nxt_a_q <= base_addr_opa;
        nxt_b_q <= base_addr_opb;
        rem_q   <= count;
      end
      if (issue) begin
        mc_address_mem_opa <= nxt_a_q;
        mc_address_mem_opb <= nxt_b_q;
        nxt_a_q <= nxt_a_q + ADDR_W'(1);
        nxt_b_q <= nxt_b_q + ADDR_W'(1);
        rem_q   <= rem_q - CNT_W'(1);
      end
      pv_q <= {pv_q[0], issue};
      pl_q <= {pl_q[0], issue && rem_one};
      if (push)
        wp_q <= wp_q + PW'(1);
      if (pop)
        rp_q <= rp_q + PW'(1);
      cnt_q <= cnt_q
             + (PW+1)'(push)
             - (PW+1)'(pop);
    end
  end

  always_ff @(posedge mem_clk) begin
    if (push) begin
      fa_q[wp_q] <= mem_data_out_opa;
      fb_q[wp_q] <= mem_data_out_opb;
      fl_q[wp_q] <= pl_q[1];
    end
  end

  assign busy     = (state_q != IDLE);
  assign op_valid = (cnt_q != '0);
  assign op_a     = op_valid ? fa_q[rp_q] : '0;
  assign op_b     = op_valid ? fb_q[rp_q] : '0;
  assign op_last  = op_valid && fl_q[rp_q];

`ifdef MC_STALL_CNT_EN
  always_ff @(posedge mem_clk) begin
    if (mem_rst || accept)
      stall_cnt <= '0;
    else if (op_valid && !op_ready
             && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
